// File: rtl/interrupt_ack_sequencer_if.sv
// rtl/interrupt_ack_sequencer_if.sv - request, acknowledge and vector bus of the PIC control stage
interface interrupt_ack_sequencer_if;
    logic [7:0] irr;
    logic [7:0] imr;
    logic       inta_n;
    logic       eoi;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic [4:0] vector_base;
    logic       int_out;
    logic [7:0] isr;
    logic [7:0] irr_clear;
    logic [7:0] data_out;
    logic       data_oe;

    // CPU / register side drives requests, acknowledge and EOI commands
    modport master (
        output irr, imr, inta_n, eoi, eoi_specific, eoi_level, vector_base,
        input  int_out, isr, irr_clear, data_out, data_oe
    );

    // sequencer side
    modport slave (
        input  irr, imr, inta_n, eoi, eoi_specific, eoi_level, vector_base,
        output int_out, isr, irr_clear, data_out, data_oe
    );
endinterface

// File: rtl/interrupt_ack_sequencer.sv
// rtl/interrupt_ack_sequencer.sv - fixed-priority resolve, INTA handshake, vector drive and ISR ownership
module interrupt_ack_sequencer #(
    parameter bit         AUTO_EOI       = 1'b0,
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    interrupt_ack_sequencer_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, REQ, ACK1, WAIT2, ACK2} state_t;

    state_t     state_q;
    logic       inta_prev_q;
    logic       int_out_q;
    logic       data_oe_q;
    logic       spurious_q;
    logic [2:0] level_q;
    logic [7:0] isr_q;
    logic [7:0] irr_clear_q;
    logic [7:0] data_out_q;

    logic       inta_fall;
    logic       inta_rise;
    logic [7:0] req_m;
    logic [7:0] cand_oh;
    logic [7:0] isr_oh;
    logic [2:0] cand_idx;
    logic       cand_valid;
    logic [7:0] eoi_clr;
    logic [7:0] set_mask;
    logic [7:0] auto_clr;

    assign inta_fall = inta_prev_q & ~bus.inta_n;
    assign inta_rise = ~inta_prev_q & bus.inta_n;

    // Lowest set bit isolated as one-hot; a lower index is a smaller one-hot value,
    // so priority against the in-service level is a plain magnitude compare.
    assign req_m      = bus.irr & ~bus.imr;
    assign cand_oh    = req_m & (~req_m + 8'd1);
    assign isr_oh     = isr_q & (~isr_q + 8'd1);
    assign cand_valid = (cand_oh != 8'd0) && ((isr_oh == 8'd0) || (cand_oh < isr_oh));

    // Encode the index of the highest-priority unmasked request
    always_comb begin
        cand_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_m[i]) cand_idx = 3'(i);
        end
    end

    // ISR bits removed by an EOI command this cycle
    always_comb begin
        eoi_clr = 8'd0;
        if (bus.eoi) eoi_clr = bus.eoi_specific ? (8'd1 << bus.eoi_level) : isr_oh;
    end

    assign set_mask = (state_q == REQ && inta_fall && cand_valid) ? (8'd1 << cand_idx) : 8'd0;
    assign auto_clr = (AUTO_EOI && state_q == ACK2 && inta_rise && !spurious_q) ? (8'd1 << level_q) : 8'd0;

    // In-service register: clears apply first so a same-cycle handshake set wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isr_q <= 8'd0;
        end else begin
            isr_q <= (isr_q & ~eoi_clr & ~auto_clr) | set_mask;
        end
    end

    // Handshake state machine with registered INT, clear pulse and vector outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            inta_prev_q <= 1'b1;
            int_out_q   <= 1'b0;
            data_oe_q   <= 1'b0;
            spurious_q  <= 1'b0;
            level_q     <= 3'd0;
            irr_clear_q <= 8'd0;
            data_out_q  <= 8'd0;
        end else begin
            inta_prev_q <= bus.inta_n;
            irr_clear_q <= 8'd0;
            case (state_q)
                IDLE: begin
                    if (cand_valid) begin
                        state_q   <= REQ;
                        int_out_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (inta_fall) begin
                        int_out_q <= 1'b0;
                        state_q   <= ACK1;
                        if (cand_valid) begin
                            level_q     <= cand_idx;
                            spurious_q  <= 1'b0;
                            irr_clear_q <= set_mask;
                        end else begin
                            level_q    <= SPURIOUS_LEVEL;
                            spurious_q <= 1'b1;
                        end
                    end else if (!cand_valid) begin
                        int_out_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                ACK1: begin
                    if (inta_rise) state_q <= WAIT2;
                end
                WAIT2: begin
                    if (inta_fall) begin
                        state_q    <= ACK2;
                        data_oe_q  <= 1'b1;
                        data_out_q <= {bus.vector_base, level_q};
                    end
                end
                ACK2: begin
                    if (inta_rise) begin
                        data_oe_q  <= 1'b0;
                        data_out_q <= 8'd0;
                        if (cand_valid) begin
                            state_q   <= REQ;
                            int_out_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.int_out   = int_out_q;
    assign bus.isr       = isr_q;
    assign bus.irr_clear = irr_clear_q;
    assign bus.data_out  = data_out_q;
    assign bus.data_oe   = data_oe_q;
endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// tb/tb_interrupt_ack_sequencer.sv - scoreboard bench for interrupt_ack_sequencer
module tb_interrupt_ack_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    interrupt_ack_sequencer_if b1 ();
    interrupt_ack_sequencer_if b2 ();

    interrupt_ack_sequencer #(.AUTO_EOI(1'b0), .SPURIOUS_LEVEL(3'd7)) dut (.clk(clk), .rst_n(rst_n), .bus(b1));
    interrupt_ack_sequencer #(.AUTO_EOI(1'b1), .SPURIOUS_LEVEL(3'd7)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    always #5 clk = ~clk;

    logic [7:0] irr_v = 8'h00;
    logic [7:0] imr_v = 8'h00;
    logic [4:0] vb    = 5'h10;
    logic [7:0] isr_m = 8'h00;

    assign b1.irr         = irr_v;
    assign b1.imr         = imr_v;
    assign b1.vector_base = vb;

    int n_cmp  = 0;
    int n_fail = 0;

    int exp_clr[$];
    int exp_vec[$];
    int exp_len[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    // A request is serviceable when its level beats every level currently in service
    function automatic bit model_valid(input logic [7:0] r, input logic [7:0] m, input logic [7:0] s);
        int c;
        c = lowest(r & ~m);
        return (c < 8) && (c < lowest(s));
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pop expectations whenever the DUT presents a clear pulse or a vector
    int   oe_run  = 0;
    logic oe_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            oe_prev = 1'b0;
            oe_run  = 0;
        end else begin
            if (b1.irr_clear != 8'h00) begin
                if (exp_clr.size() == 0) check("irr_clear_unexpected", 32'(b1.irr_clear), 32'h0);
                else check("irr_clear", 32'(b1.irr_clear), 32'(exp_clr.pop_front()));
            end
            if (b1.data_oe && !oe_prev) begin
                if (exp_vec.size() == 0) check("data_oe_unexpected", 32'(b1.data_oe), 32'h0);
                else check("vector", 32'(b1.data_out), 32'(exp_vec.pop_front()));
            end
            if (b1.data_oe) oe_run++;
            if (!b1.data_oe && oe_prev) begin
                if (exp_len.size() > 0) check("data_oe_len", 32'(oe_run), 32'(exp_len.pop_front()));
                oe_run = 0;
            end
            oe_prev = b1.data_oe;
        end
    end

    task automatic do_eoi(input bit spec, input int lvl);
        b1.eoi = 1'b1;
        b1.eoi_specific = spec;
        b1.eoi_level = 3'(lvl);
        tick(1);
        b1.eoi = 1'b0;
        if (spec) isr_m &= ~(8'(1 << lvl));
        else if (isr_m != 8'h00) isr_m &= ~(8'(1 << lowest(isr_m)));
        check("isr_eoi", 32'(b1.isr), 32'(isr_m));
    endtask

    // Two INTA pulses; optional specific EOI and request withdrawal on the first falling edge
    task automatic handshake(input int low1, input int high1, input int len2, input int eoi_lvl, input bit withdraw);
        bit         was_req;
        bit         now_valid;
        int         lvl;
        logic [7:0] bit_m;
        was_req = model_valid(irr_v, imr_v, isr_m);
        b1.inta_n = 1'b0;
        if (withdraw) irr_v = 8'h00;
        if (eoi_lvl >= 0) begin
            b1.eoi = 1'b1;
            b1.eoi_specific = 1'b1;
            b1.eoi_level = 3'(eoi_lvl);
        end
        now_valid = model_valid(irr_v, imr_v, isr_m);
        lvl = 7;
        bit_m = 8'h00;
        if (was_req && now_valid) begin
            lvl = lowest(irr_v & ~imr_v);
            bit_m = 8'(1 << lvl);
            exp_clr.push_back(int'(bit_m));
        end
        if (eoi_lvl >= 0) isr_m &= ~(8'(1 << eoi_lvl));
        isr_m |= bit_m;
        if (was_req) begin
            exp_vec.push_back(int'({vb, 3'(lvl)}));
            exp_len.push_back(len2);
        end
        tick(1);
        b1.eoi = 1'b0;
        check("int_out_ack", 32'(b1.int_out), 32'h0);
        tick(low1 - 1);
        b1.inta_n = 1'b1;
        irr_v &= ~bit_m;
        tick(high1);
        b1.inta_n = 1'b0;
        tick(len2);
        b1.inta_n = 1'b1;
        tick(1);
        check("isr_hs", 32'(b1.isr), 32'(isr_m));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b1.inta_n = 1'b1; b1.eoi = 1'b0; b1.eoi_specific = 1'b0; b1.eoi_level = 3'd0;
        b2.irr = 8'h00; b2.imr = 8'h00; b2.inta_n = 1'b1; b2.eoi = 1'b0;
        b2.eoi_specific = 1'b0; b2.eoi_level = 3'd0; b2.vector_base = 5'h10;
        tick(3);
        check("rst_int_out", 32'(b1.int_out), 32'h0);
        check("rst_isr", 32'(b1.isr), 32'h0);
        check("rst_irr_clear", 32'(b1.irr_clear), 32'h0);
        check("rst_data_out", 32'(b1.data_out), 32'h0);
        check("rst_data_oe", 32'(b1.data_oe), 32'h0);
        rst_n = 1'b1;
        tick(1);

        // basic handshake
        irr_v = 8'h08;
        tick(1);
        check("basic_int_out", 32'(b1.int_out), 32'h1);
        handshake(1, 1, 2, -1, 1'b0);

        // priority and nesting
        irr_v = 8'h30;
        tick(3);
        check("lower_prio_blocked", 32'(b1.int_out), 32'h0);
        irr_v = 8'h02;
        tick(2);
        check("nest_int_out", 32'(b1.int_out), 32'h1);
        handshake(2, 1, 1, -1, 1'b0);
        check("nest_isr", 32'(b1.isr), 32'h0A);

        // masking and withdrawal
        irr_v = 8'h01; imr_v = 8'h01;
        tick(3);
        check("masked", 32'(b1.int_out), 32'h0);
        imr_v = 8'h00;
        tick(2);
        check("unmasked", 32'(b1.int_out), 32'h1);
        irr_v = 8'h00;
        tick(2);
        check("withdrawn", 32'(b1.int_out), 32'h0);
        check("withdrawn_isr", 32'(b1.isr), 32'h0A);

        // EOI
        do_eoi(1'b1, 3);
        do_eoi(1'b0, 0);
        irr_v = 8'h04; tick(2); handshake(1, 2, 1, -1, 1'b0);
        irr_v = 8'h02; tick(2); handshake(1, 1, 3, -1, 1'b0);
        check("eoi_setup", 32'(b1.isr), 32'h06);
        do_eoi(1'b0, 0);
        check("eoi_nonspec", 32'(b1.isr), 32'h04);
        do_eoi(1'b1, 2);
        check("eoi_spec", 32'(b1.isr), 32'h00);

        // set wins over a same-cycle specific EOI
        irr_v = 8'h10; tick(2);
        handshake(1, 1, 1, 4, 1'b0);
        check("set_wins", 32'(b1.isr), 32'h10);
        do_eoi(1'b1, 4);

        // spurious acknowledge
        irr_v = 8'h08; tick(2);
        check("spur_int_out", 32'(b1.int_out), 32'h1);
        handshake(1, 1, 2, -1, 1'b1);
        check("spur_isr", 32'(b1.isr), 32'h00);

        // automatic EOI instance
        b2.irr = 8'h08;
        tick(2);
        check("ae_int_out", 32'(b2.int_out), 32'h1);
        b2.inta_n = 1'b0; tick(1);
        b2.irr = 8'h00; b2.inta_n = 1'b1; tick(1);
        check("ae_isr_set", 32'(b2.isr), 32'h08);
        b2.inta_n = 1'b0; tick(2);
        check("ae_oe", 32'(b2.data_oe), 32'h1);
        check("ae_vector", 32'(b2.data_out), 32'h83);
        b2.inta_n = 1'b1; tick(1);
        check("ae_isr_clr", 32'(b2.isr), 32'h00);
        check("ae_oe_off", 32'(b2.data_oe), 32'h0);

        // reset during WAIT2
        irr_v = 8'h20; tick(2);
        check("rmid_int_out", 32'(b1.int_out), 32'h1);
        exp_clr.push_back(32'h20);
        b1.inta_n = 1'b0; tick(1);
        b1.inta_n = 1'b1; irr_v = 8'h00; tick(1);
        rst_n = 1'b0; tick(1);
        check("rmid_int_out0", 32'(b1.int_out), 32'h0);
        check("rmid_isr", 32'(b1.isr), 32'h0);
        check("rmid_irr_clear", 32'(b1.irr_clear), 32'h0);
        check("rmid_data_out", 32'(b1.data_out), 32'h0);
        check("rmid_data_oe", 32'(b1.data_oe), 32'h0);
        rst_n = 1'b1; isr_m = 8'h00; tick(1);
        b1.inta_n = 1'b0; tick(2); b1.inta_n = 1'b1; tick(1);
        b1.inta_n = 1'b0; tick(2); b1.inta_n = 1'b1; tick(2);
        check("rmid_ignored_isr", 32'(b1.isr), 32'h0);
        check("rmid_ignored_int", 32'(b1.int_out), 32'h0);

        // randomized traffic against the reference model
        for (int it = 0; it < 250; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3) begin
                do_eoi(1'($urandom_range(0, 1)), $urandom_range(0, 7));
            end else begin
                irr_v = 8'($urandom) & 8'($urandom);
                imr_v = 8'($urandom) & 8'($urandom) & 8'($urandom);
                vb    = 5'($urandom);
                tick(3);
                check("rand_int_out", 32'(b1.int_out), 32'(model_valid(irr_v, imr_v, isr_m)));
                if (r != 3)
                    handshake($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3), -1,
                              $urandom_range(0, 9) == 0);
            end
        end

        tick(5);
        check("queues_drained", 32'(exp_clr.size() + exp_vec.size() + exp_len.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
